// File: rtl/stop_watch_pkg.sv
// Shared display definitions for the stopwatch: segment patterns, position encoding, snapshot.
package stop_watch_pkg;

    localparam int unsigned NUM_POS = 5;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    localparam logic [6:0] DIGIT_SEG [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef enum logic [2:0] {
        POS_D0   = 3'd0,
        POS_D1   = 3'd1,
        POS_D2   = 3'd2,
        POS_D3   = 3'd3,
        POS_SIGN = 3'd4
    } pos_e;

    typedef struct packed {
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
        logic       minus;
        logic       blank;
    } snap_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; values above 9 show "E".
module bcd_to_seg
    import stop_watch_pkg::*;
(
    input  logic [3:0] d_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_E;
        for (int i = 0; i < 10; i++) begin
            if (d_i == 4'(i)) seg_o = DIGIT_SEG[i];
        end
    end

endmodule

// File: rtl/stop_watch_disp_mux.sv
// Scans the stopwatch digits and sign across a 5-position common-anode display,
// one position per refresh interval, from a snapshot taken at each frame boundary.
module stop_watch_disp_mux
    import stop_watch_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [3:0] d3_i,
    input  logic [3:0] d2_i,
    input  logic [3:0] d1_i,
    input  logic [3:0] d0_i,
    input  logic       minus_flag_i,
    input  logic       blank_lead_i,
    output logic [4:0] an_o,
    output logic [6:0] seg_o,
    output logic       dp_o
);

    localparam int unsigned TickW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [TickW-1:0] tick_q, tick_d;
    pos_e             pos_q, pos_d;
    snap_t            snap_q, snap_d;
    logic             load_pending_q;
    logic [4:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             advance;
    logic [3:0]       digit;
    logic [6:0]       digit_seg;

    assign advance = (tick_q == TickW'(REFRESH_DIV - 1));

    always_comb begin
        tick_d = advance ? '0 : tick_q + 1'b1;
        pos_d  = pos_q;
        if (advance) pos_d = (pos_q == POS_SIGN) ? POS_D0 : pos_e'(pos_q + 3'd1);
        snap_d = snap_q;
        // Frame boundary and the post-reset load share one path so pos 0 never sees stale data.
        if (load_pending_q || (advance && pos_q == POS_SIGN)) begin
            snap_d = '{d3: d3_i, d2: d2_i, d1: d1_i, d0: d0_i,
                       minus: minus_flag_i, blank: blank_lead_i};
        end
    end

    always_comb begin
        case (pos_q)
            POS_D0:  digit = snap_q.d0;
            POS_D1:  digit = snap_q.d1;
            POS_D2:  digit = snap_q.d2;
            POS_D3:  digit = snap_q.d3;
            default: digit = 4'd0;
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .d_i   (digit),
        .seg_o (digit_seg)
    );

    always_comb begin
        an_d  = 5'b11111;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        // Keep dark until the first snapshot has been taken.
        if (!load_pending_q) begin
            case (pos_q)
                POS_D0, POS_D1, POS_D2: begin
                    an_d       = 5'b11111;
                    an_d[pos_q] = 1'b0;
                    seg_d      = digit_seg;
                    dp_d       = (pos_q != POS_D1);
                end
                POS_D3: begin
                    if (!(snap_q.blank && snap_q.d3 == 4'd0)) begin
                        an_d  = 5'b10111;
                        seg_d = digit_seg;
                        dp_d  = 1'b0;
                    end
                end
                POS_SIGN: begin
                    if (snap_q.minus) begin
                        an_d  = 5'b01111;
                        seg_d = SEG_DASH;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tick_q         <= '0;
            pos_q          <= POS_D0;
            snap_q         <= '0;
            load_pending_q <= 1'b1;
            an_q           <= 5'b11111;
            seg_q          <= SEG_BLANK;
            dp_q           <= 1'b1;
        end else begin
            tick_q         <= tick_d;
            pos_q          <= pos_d;
            snap_q         <= snap_d;
            load_pending_q <= 1'b0;
            an_q           <= an_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
        end
    end

    assign an_o  = an_q;
    assign seg_o = seg_q;
    assign dp_o  = dp_q;

endmodule

// File: tb/tb_stop_watch_disp_mux.sv
// Self-checking bench: per-edge comparison against a frame/time arithmetic display model.
module tb_stop_watch_disp_mux;

    localparam int R = 4;
    localparam int FRAME = 5 * R;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] d3, d2, d1, d0;
    logic       minus_flag, blank_lead;
    logic [4:0] an;
    logic [6:0] seg;
    logic       dp;

    int passed = 0;
    int total  = 0;
    int e      = 0;
    logic [17:0] hist [0:8191];

    stop_watch_disp_mux #(.REFRESH_DIV(R)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .d3_i         (d3),
        .d2_i         (d2),
        .d1_i         (d1),
        .d0_i         (d0),
        .minus_flag_i (minus_flag),
        .blank_lead_i (blank_lead),
        .an_o         (an),
        .seg_o        (seg),
        .dp_o         (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0000110;
        endcase
    endfunction

    // Display after edge number e since reset release. Position p is shown for R cycles each;
    // the snapshot comes from edge 1 or from the most recent multiple of the frame length.
    function automatic void model(input int en, output logic [4:0] ea, output logic [6:0] es,
                                  output logic ed);
        int m, p, src, v;
        logic [17:0] s;
        ea = 5'b11111; es = 7'b1111111; ed = 1'b1;
        if (en >= 2) begin
            m   = en - 1;
            p   = (m / R) % 5;
            src = (m < FRAME) ? 1 : (m / FRAME) * FRAME;
            s   = hist[src];
            if (p < 4) begin
                v = int'(s[2 + 4*p +: 4]);
                if (!(p == 3 && s[0] && v == 0)) begin
                    ea = ~(5'b00001 << p);
                    es = ref_seg(v);
                    ed = !(p == 1 || p == 3);
                end
            end else if (s[1]) begin
                ea = 5'b01111;
                es = 7'b0111111;
            end
        end
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, got, exp, e);
    endtask

    task automatic step();
        logic [4:0] ea;
        logic [6:0] es;
        logic       ed;
        @(posedge clk);
        if (reset) e = 0;
        else begin
            e++;
            hist[e] = {d3, d2, d1, d0, minus_flag, blank_lead};
        end
        #1;
        model(e, ea, es, ed);
        chk("an", int'(an), int'(ea));
        chk("seg", int'(seg), int'(es));
        chk("dp", int'(dp), int'(ed));
        chk("onehot", int'($countones(~an) <= 1), 1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_digits(input int a, input int b, input int c, input int d);
        d3 = 4'(a); d2 = 4'(b); d1 = 4'(c); d0 = 4'(d);
    endtask

    initial begin
        reset = 1'b1; minus_flag = 1'b0; blank_lead = 1'b0;
        set_digits(1, 2, 3, 4);
        run(3);
        chk("reset_an", int'(an), 5'h1f);
        chk("reset_seg", int'(seg), 7'h7f);
        reset = 1'b0;
        run(2);
        chk("first_pos0_an", int'(an), 5'b11110);
        chk("first_pos0_seg", int'(seg), 7'b0011001);
        chk("first_pos0_dp", int'(dp), 1);
        run(2 * FRAME);

        minus_flag = 1'b1;
        set_digits(9, 5, 9, 9);
        run(2 * FRAME);

        minus_flag = 1'b0; blank_lead = 1'b1;
        set_digits(0, 3, 1, 4);
        run(2 * FRAME);
        blank_lead = 1'b0;
        run(2 * FRAME);

        // Mid-frame change of d0 while pos 2 is lit.
        run(2 * R + 1);
        d0 = 4'd7;
        run(2 * FRAME);

        d0 = 4'hC;
        run(2 * FRAME);

        // One-cycle reset in the middle of a scan.
        run(2 * R + 2);
        reset = 1'b1;
        step();
        chk("midreset_an", int'(an), 5'h1f);
        reset = 1'b0;
        set_digits(8, 0, 6, 2);
        run(FRAME);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) begin
                set_digits($urandom_range(15), $urandom_range(15), $urandom_range(15),
                           $urandom_range(15));
                minus_flag = 1'($urandom_range(1));
                blank_lead = 1'($urandom_range(1));
            end
            if ($urandom_range(3) == 0) d3 = 4'd0;
            reset = ($urandom_range(149) == 0);
            step();
        end
        reset = 1'b0;
        run(FRAME);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
